// File: rtl/mpsoc_timestamp_capture_if.sv
// ---------------------------------------------------------------------------
// mpsoc_timestamp_capture_if
//
// Groups the two handshaked buses of the timestamp capture block:
//   * the Avalon-MM initiator port that talks to the interval timer slave
//   * the valid/ready stream that hands captured timestamps to a consumer
//
// Signals:
//   m_address      3  timer register offset (initiator -> timer)
//   m_chipselect   1  bus request
//   m_write_n      1  active-low write strobe
//   m_read_n       1  active-low read strobe
//   m_writedata   16  write data
//   m_readdata    16  read data, valid the cycle after read acceptance
//   m_waitrequest  1  timer stall; the command is held while high
//   ts_valid       1  a timestamp is available at the head of the FIFO
//   ts_ready       1  consumer accepts the head entry
//   ts_data       32  head snapshot {high half, low half}
//   ts_seq         8  head sequence number
//
// Modports:
//   master  the capture block (drives commands, sources the stream)
//   slave   the environment (timer slave plus stream consumer)
// ---------------------------------------------------------------------------
interface mpsoc_timestamp_capture_if;

   logic [2:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic        m_read_n;
   logic [15:0] m_writedata;
   logic [15:0] m_readdata;
   logic        m_waitrequest;

   logic        ts_valid;
   logic        ts_ready;
   logic [31:0] ts_data;
   logic [7:0]  ts_seq;

   modport master (
      output m_address,
      output m_chipselect,
      output m_write_n,
      output m_read_n,
      output m_writedata,
      input  m_readdata,
      input  m_waitrequest,
      output ts_valid,
      input  ts_ready,
      output ts_data,
      output ts_seq
   );

   modport slave (
      input  m_address,
      input  m_chipselect,
      input  m_write_n,
      input  m_read_n,
      input  m_writedata,
      output m_readdata,
      output m_waitrequest,
      input  ts_valid,
      output ts_ready,
      input  ts_data,
      input  ts_seq
   );

endinterface

// File: rtl/mpsoc_timestamp_capture.sv
// ---------------------------------------------------------------------------
// mpsoc_timestamp_capture
//
// Hardware-only driver for a 16-bit register-mapped interval timer. After
// reset it can program the 32-bit period and start the timer in continuous
// mode. Every trigger then latches the timer snapshot, reads back both
// 16-bit halves and stores a sequence-tagged 32-bit timestamp in a small
// FIFO that a consumer drains through a valid/ready stream.
//
// Timer register offsets used: 1 control, 2/3 period low/high,
// 4/5 snapshot low/high (a write to 4 latches the counter).
//
// Parameters:
//   PERIOD      32-bit period written during init
//   AUTO_START  non-zero runs the init write sequence after reset
//   FIFO_DEPTH  timestamp entries, power of two in 2..16
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   trigger     capture request, sampled every cycle
//   drop_clr    synchronous clear of drop_count (wins over an increment)
//   bus         timer initiator port and timestamp stream (master modport)
//   drop_count  saturating count of lost triggers
//   init_done   high once init has finished (or was skipped)
//   busy        capture in progress (SNAP_WR through PUSH)
// ---------------------------------------------------------------------------
module mpsoc_timestamp_capture #(
   parameter logic [31:0] PERIOD     = 32'hFFFF_FFFF,
   parameter int          AUTO_START = 1,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             trigger,
   input  logic                             drop_clr,
   mpsoc_timestamp_capture_if.master        bus,
   output logic [7:0]                       drop_count,
   output logic                             init_done,
   output logic                             busy
);

   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int AW1 = AW + 1;
   localparam logic [AW:0] DEPTH_CNT = AW1'(FIFO_DEPTH);

   typedef enum logic [3:0] {
      INIT_PL,
      INIT_PH,
      INIT_CTL,
      IDLE,
      SNAP_WR,
      RD_L,
      RD_L_WAIT,
      RD_H,
      RD_H_WAIT,
      PUSH
   } state_t;

   localparam state_t RESET_STATE   = (AUTO_START != 0) ? INIT_PL : IDLE;
   localparam logic   INIT_DONE_RST = (AUTO_START != 0) ? 1'b0 : 1'b1;

   // control word: bit 2 start, bit 1 continuous, bit 0 irq enable (off)
   localparam logic [15:0] CTL_START_CONT = 16'h0006;

   state_t       state;
   state_t       state_next;

   logic         cmd_cs;
   logic         cmd_wr;
   logic         cmd_rd;
   logic [2:0]   cmd_addr;
   logic [15:0]  cmd_data;
   logic         init_set;
   logic         cap_lo;
   logic         cap_hi;
   logic         push_req;

   logic         pending;
   logic [15:0]  snap_lo;
   logic [15:0]  snap_hi;
   logic [7:0]   seq_cnt;

   logic [39:0]  fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]  fifo_cnt;
   logic         fifo_full;
   logic         push_ok;
   logic         pop;

   logic         drop_trig;
   logic         drop_push;
   logic [8:0]   drop_sum;

   // State register. Reset lands in the init sequence or directly in IDLE
   // depending on AUTO_START, so a reset mid-capture reruns init.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RESET_STATE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and bus command decode. Every command state holds its
   // command until waitrequest is seen low, which is the cycle the timer
   // accepts it. The two WAIT states exist because read data only shows
   // up the cycle after the read is accepted.
   always_comb begin
      state_next = state;
      cmd_cs     = 1'b0;
      cmd_wr     = 1'b0;
      cmd_rd     = 1'b0;
      cmd_addr   = 3'd0;
      cmd_data   = 16'h0000;
      init_set   = 1'b0;
      cap_lo     = 1'b0;
      cap_hi     = 1'b0;
      push_req   = 1'b0;

      case (state)
         INIT_PL: begin
            cmd_cs   = 1'b1;
            cmd_wr   = 1'b1;
            cmd_addr = 3'd2;
            cmd_data = PERIOD[15:0];
            if (!bus.m_waitrequest) state_next = INIT_PH;
         end
         INIT_PH: begin
            cmd_cs   = 1'b1;
            cmd_wr   = 1'b1;
            cmd_addr = 3'd3;
            cmd_data = PERIOD[31:16];
            if (!bus.m_waitrequest) state_next = INIT_CTL;
         end
         INIT_CTL: begin
            cmd_cs   = 1'b1;
            cmd_wr   = 1'b1;
            cmd_addr = 3'd1;
            cmd_data = CTL_START_CONT;
            if (!bus.m_waitrequest) begin
               state_next = IDLE;
               init_set   = 1'b1;
            end
         end
         IDLE: begin
            if (trigger || pending) state_next = SNAP_WR;
         end
         SNAP_WR: begin
            // any write to the snapshot register freezes all 32 bits, so
            // the two halves read afterwards belong to the same instant
            cmd_cs   = 1'b1;
            cmd_wr   = 1'b1;
            cmd_addr = 3'd4;
            if (!bus.m_waitrequest) state_next = RD_L;
         end
         RD_L: begin
            cmd_cs   = 1'b1;
            cmd_rd   = 1'b1;
            cmd_addr = 3'd4;
            if (!bus.m_waitrequest) state_next = RD_L_WAIT;
         end
         RD_L_WAIT: begin
            cap_lo     = 1'b1;
            state_next = RD_H;
         end
         RD_H: begin
            cmd_cs   = 1'b1;
            cmd_rd   = 1'b1;
            cmd_addr = 3'd5;
            if (!bus.m_waitrequest) state_next = RD_H_WAIT;
         end
         RD_H_WAIT: begin
            cap_hi     = 1'b1;
            state_next = PUSH;
         end
         PUSH: begin
            push_req   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = RESET_STATE;
         end
      endcase
   end

   // The bus is decoded straight from the state, so the reset state would
   // otherwise present the first init write while reset is still held.
   // Qualifying with reset_n keeps the bus idle for the whole reset.
   assign bus.m_chipselect = cmd_cs & reset_n;
   assign bus.m_write_n    = ~(cmd_wr & reset_n);
   assign bus.m_read_n     = ~(cmd_rd & reset_n);
   assign bus.m_address    = reset_n ? cmd_addr : 3'd0;
   assign bus.m_writedata  = reset_n ? cmd_data : 16'h0000;

   assign busy = (state != IDLE) && (state != INIT_PL) &&
                 (state != INIT_PH) && (state != INIT_CTL);

   // One-deep pending request. Outside IDLE a trigger is remembered here.
   // In IDLE the pending request is consumed by the capture that starts;
   // if a fresh trigger arrives in that same cycle it takes the freed slot
   // instead of being silently lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
      end else if (state == IDLE) begin
         pending <= pending & trigger;
      end else if (trigger) begin
         pending <= 1'b1;
      end
   end

   // init_done is sticky until the next reset; without AUTO_START there is
   // nothing to wait for, so it comes out of reset already set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         init_done <= INIT_DONE_RST;
      end else if (init_set) begin
         init_done <= 1'b1;
      end
   end

   // Snapshot halves as they come back from the timer. Cleared on reset so
   // an aborted capture leaves nothing behind.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap_lo <= 16'h0000;
         snap_hi <= 16'h0000;
      end else begin
         if (cap_lo) snap_lo <= bus.m_readdata;
         if (cap_hi) snap_hi <= bus.m_readdata;
      end
   end

   // Fullness is judged before any same-cycle pop, so a push into a full
   // FIFO is always a drop even while the consumer is draining it.
   assign fifo_full = (fifo_cnt == DEPTH_CNT);
   assign push_ok   = push_req && !fifo_full;
   assign pop       = (fifo_cnt != '0) && bus.ts_ready;

   // Sequence tags advance only for entries that were actually stored, so
   // gaps in the stream show up in drop_count, not in the sequence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq_cnt <= 8'd0;
      end else if (push_ok) begin
         seq_cnt <= seq_cnt + 8'd1;
      end
   end

   // FIFO storage. Entries are {seq, high, low}; the array is cleared on
   // reset so the head view reads zero until the first push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= 40'd0;
         end
      end else if (push_ok) begin
         fifo_mem[wr_ptr] <= {seq_cnt, snap_hi, snap_lo};
      end
   end

   // FIFO pointers and occupancy. The depth is a power of two, so the
   // pointers wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop) begin
            fifo_cnt <= fifo_cnt + 1'b1;
         end else if (pop && !push_ok) begin
            fifo_cnt <= fifo_cnt - 1'b1;
         end
      end
   end

   assign bus.ts_valid = (fifo_cnt != '0);
   assign bus.ts_data  = fifo_mem[rd_ptr][31:0];
   assign bus.ts_seq   = fifo_mem[rd_ptr][39:32];

   // A trigger is lost either when it arrives while a request is already
   // pending, or when its finished capture finds the FIFO full. Both can
   // happen in the same cycle, so up to two are added at once.
   assign drop_trig = trigger && pending && (state != IDLE);
   assign drop_push = push_req && fifo_full;

   always_comb begin
      drop_sum = {1'b0, drop_count} + 9'(drop_trig) + 9'(drop_push);
   end

   // Saturating loss counter; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_count <= 8'd0;
      end else if (drop_clr) begin
         drop_count <= 8'd0;
      end else if (drop_sum > 9'd255) begin
         drop_count <= 8'hFF;
      end else begin
         drop_count <= drop_sum[7:0];
      end
   end

endmodule

// File: doc/mpsoc_timestamp_capture.md
# mpsoc_timestamp_capture

Avalon-MM initiator that drives a 16-bit register-mapped interval timer slave (period at offsets 2/3, control at 1, snapshot at 4/5) from hardware, with no CPU involvement. After reset it optionally programs and starts the timer. On each `trigger` pulse it:

- writes the snapshot register,
- reads both snapshot halves,
- pushes a sequence-tagged 32-bit timestamp into an internal FIFO drained through a valid/ready stream.

It sits between per-core event sources in the MPSoC and a timer instance on the same clock domain.

## Interface
Parameters:
- PERIOD, 32'hFFFF_FFFF, 32-bit period value written to the timer during init.
- AUTO_START, 1, 1 runs the init write sequence after reset; 0 skips it.
- FIFO_DEPTH, 4, number of timestamp entries; power of two, 2..16.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- trigger  in  1  capture request, sampled every cycle
- drop_clr  in  1  synchronous clear of drop_count
- m_address  out  3  timer register offset
- m_chipselect  out  1  bus request
- m_write_n  out  1  active-low write
- m_read_n  out  1  active-low read
- m_writedata  out  16  write data
- m_readdata  in  16  timer read data, valid the cycle after read acceptance
- m_waitrequest  in  1  slave stall; the command is held while high
- ts_valid  out  1  FIFO non-empty
- ts_ready  in  1  consumer accepts the head entry
- ts_data  out  32  head snapshot, {high half, low half}
- ts_seq  out  8  head sequence number
- drop_count  out  8  saturating count of lost triggers
- init_done  out  1  high once init has finished (or was skipped)
- busy  out  1  capture in progress

## Operation
FSM states: INIT_PL, INIT_PH, INIT_CTL, IDLE, SNAP_WR, RD_L, RD_L_WAIT, RD_H, RD_H_WAIT, PUSH.

- **Reset entry:** state is INIT_PL if AUTO_START=1, else IDLE.
- **INIT_PL:** write address 2, data PERIOD[15:0].
- **INIT_PH:** write address 3, data PERIOD[31:16].
- **INIT_CTL:** write address 1, data 16'h0006 (start, continuous, irq disabled). Exit to IDLE and set init_done.
- **IDLE:** go to SNAP_WR when trigger or pending is set; clear pending on exit.
- **SNAP_WR:** write address 4, data 0. This latches the full 32-bit counter, so the two halves read next are coherent.
- **RD_L:** read address 4. RD_L_WAIT captures m_readdata into low[15:0].
- **RD_H:** read address 5. RD_H_WAIT captures m_readdata into high[15:0].
- **PUSH:**
  - If the FIFO is not full: write {high, low} with seq_cnt, then increment seq_cnt (8-bit, wraps 255→0).
  - If the FIFO is full: discard the entry, increment drop_count, leave seq_cnt unchanged.
  - Either way, return to IDLE.

Bus command rules:
- Each write or read state holds its command (chipselect=1, address, data, strobe low) until m_waitrequest is sampled low, then advances.
- Only one strobe is active at a time.
- In all other states: chipselect=0, write_n=1, read_n=1.

Trigger handling:
- trigger high while busy (any state other than IDLE or INIT_*) sets a 1-deep pending flag.
- trigger while pending is already set increments drop_count.
- trigger during INIT_* is treated the same as busy.

Counters and outputs:
- drop_count saturates at 255.
- drop_clr zeroes drop_count and takes priority over a same-cycle increment.
- busy is high in SNAP_WR through PUSH.
- ts_valid, ts_data and ts_seq are driven from the FIFO head (first-word registered view).
- A pop occurs when ts_valid && ts_ready.
- A simultaneous push and pop on a full FIFO is a drop: full is evaluated before the pop.

## Timing
Reset values:
- m_chipselect 0, m_write_n 1, m_read_n 1, m_address 0, m_writedata 0.
- ts_valid 0, ts_data 0, ts_seq 0, seq_cnt 0.
- drop_count 0, init_done 0 (or 1 if AUTO_START=0), busy 0, pending 0.
- FIFO empty.

Latency, with m_waitrequest low throughout:
- The init writes occupy cycles 0–2 after reset release; init_done rises in cycle 3.
- A trigger sampled in IDLE at cycle T gives: SNAP_WR at T+1, RD_L at T+2, low captured at the end of T+3, RD_H at T+4, high captured at the end of T+5, PUSH at T+6, ts_valid at T+7.
- The fastest trigger-to-trigger capture rate is one capture per 7 cycles.
- Each cycle of waitrequest stall adds one cycle to the state it occurs in.

Asynchronous reset mid-capture aborts immediately:
- bus outputs go idle within the reset assertion;
- the partial timestamp is discarded;
- on release, the AUTO_START init sequence reruns.

## Test plan
- **Reset and init:** AUTO_START=1, PERIOD=32'h0001_86A0, no stall → writes (2,16'h86A0), (3,16'h0001), (1,16'h0006) on consecutive cycles; init_done rises the cycle after.
- **Single capture:** timer model snapshot 32'h1234_5678 → bus sequence write 4, read 4, read 5; ts_data=32'h1234_5678 and ts_seq=0 at T+7.
- **Waitrequest stall:** 3 stall cycles on the RD_H command → address, read_n and chipselect held stable throughout; ts_valid appears at T+10 with correct data.
- **Trigger while busy:** second trigger at T+3 and third at T+4 → two FIFO entries with seq 0 and 1; drop_count=1.
- **FIFO overflow:** FIFO_DEPTH=4, ts_ready=0, 6 spaced triggers → 4 entries with seq 0..3; drop_count=2; asserting drop_clr with a same-cycle drop leaves drop_count=0.
- **Reset mid-capture:** assert reset_n=0 in RD_L_WAIT → all outputs return to reset values; FIFO empty; init sequence repeats after release; next capture has seq 0.
